// File: rtl/axil_led_bank.sv
// -----------------------------------------------------------------------------
// axil_led_bank
//   AXI4-Lite slave exposing the build-ID registers (git hash, timestamp) next
//   to a bank of NUM_CH independently programmable LED blink channels. Each
//   channel owns a 32-bit free-running counter; the LED follows counter bit DIV
//   (blink), or optionally a PWM compare of the counter's low byte against DUTY.
//
// Optional feature macro: LED_BANK_PWM_EN
//   defined   : CH[i].MODE=1 selects PWM, led = cnt[7:0] < DUTY
//   undefined : DUTY/MODE are not stored and read as 0; blink only
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN   clock, asynchronous active-low reset
//   git_hash[63:0], timestamp   build ID inputs, sampled when a read is accepted
//   S_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite slave
//   led_o[NUM_CH-1:0]           registered LED drive, 1 = on
//
// Register map (word index = ADDR[6:2])
//   0x00 GIT_LO  0x04 GIT_HI  0x08 TSTAMP  0x0C CTRL(bit0 GEN)  0x10 STATUS
//   0x14 SCRATCH  0x20+4*i CH[i] = {MODE[24], DUTY[23:16], EN[8], DIV[4:0]}
// -----------------------------------------------------------------------------
module axil_led_bank #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int NUM_CH             = 2,
   parameter int RST_DIV            = 26
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [63:0]                     git_hash,
   input  logic [31:0]                     timestamp,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_CH-1:0]               led_o
);

   localparam int WIDX = C_S_AXI_ADDR_WIDTH - 2;

   localparam logic [WIDX-1:0] A_GIT_LO  = WIDX'(0);
   localparam logic [WIDX-1:0] A_GIT_HI  = WIDX'(1);
   localparam logic [WIDX-1:0] A_TSTAMP  = WIDX'(2);
   localparam logic [WIDX-1:0] A_CTRL    = WIDX'(3);
   localparam logic [WIDX-1:0] A_STATUS  = WIDX'(4);
   localparam logic [WIDX-1:0] A_SCRATCH = WIDX'(5);
   localparam logic [WIDX-1:0] A_CH_BASE = WIDX'(8);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // bus state
   logic        r_awready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic        r_arready;
   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   // register file
   logic        r_gen;
   logic [31:0] r_scratch;
   logic [4:0]  r_div [NUM_CH];
   logic        r_en  [NUM_CH];
`ifdef LED_BANK_PWM_EN
   logic [7:0]  r_duty [NUM_CH];
   logic        r_mode [NUM_CH];
`endif

   // channel datapath
   logic [31:0]       r_cnt [NUM_CH];
   logic [NUM_CH-1:0] r_led;

   logic [WIDX-1:0]   w_aw_word;
   logic [WIDX-1:0]   w_ar_word;
   logic              w_wr_go;
   logic              w_rd_go;
   logic [NUM_CH-1:0] w_ch_wr;
   logic [NUM_CH-1:0] w_div_chg;
   logic [31:0]       w_ch_rd [NUM_CH];
   logic [31:0]       w_rd_data;
   logic              w_rd_err;
   logic              w_unused;

   assign w_aw_word = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_ar_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // READY is registered, so it is suppressed while already high to keep it a
   // single-cycle pulse; the handshake edge is the one where READY is high.
   assign w_wr_go = S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
   assign w_rd_go = S_AXI_ARVALID & ~r_rvalid & ~r_arready;

   function automatic logic f_mapped(input logic [WIDX-1:0] w);
      logic m;
      m = (w <= A_SCRATCH);
      for (int unsigned i = 0; i < NUM_CH; i++)
         if (w == A_CH_BASE + WIDX'(i)) m = 1'b1;
      return m;
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_ch_wr[i]   = r_awready & (w_aw_word == A_CH_BASE + WIDX'(i));
         w_div_chg[i] = w_ch_wr[i] & S_AXI_WSTRB[0] & (S_AXI_WDATA[4:0] != r_div[i]);
`ifdef LED_BANK_PWM_EN
         w_ch_rd[i]   = {7'd0, r_mode[i], r_duty[i], 7'd0, r_en[i], 3'd0, r_div[i]};
`else
         w_ch_rd[i]   = {23'd0, r_en[i], 3'd0, r_div[i]};
`endif
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_err  = 1'b0;
      case (w_ar_word)
         A_GIT_LO:  w_rd_data = git_hash[31:0];
         A_GIT_HI:  w_rd_data = git_hash[63:32];
         A_TSTAMP:  w_rd_data = timestamp;
         A_CTRL:    w_rd_data = {31'd0, r_gen};
         A_STATUS:  w_rd_data = 32'(r_led);
         A_SCRATCH: w_rd_data = r_scratch;
         default: begin
            w_rd_err = 1'b1;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
               if (w_ar_word == A_CH_BASE + WIDX'(i)) begin
                  w_rd_err  = 1'b0;
                  w_rd_data = w_ch_rd[i];
               end
            end
         end
      endcase
   end

   // write channel and register file
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_gen     <= 1'b1;
         r_scratch <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_div[i] <= 5'(RST_DIV);
            r_en[i]  <= 1'b1;
`ifdef LED_BANK_PWM_EN
            r_duty[i] <= '0;
            r_mode[i] <= 1'b0;
`endif
         end
      end else begin
         r_awready <= w_wr_go;
         if (r_awready) begin
            r_bvalid <= 1'b1;
            r_bresp  <= f_mapped(w_aw_word) ? RESP_OKAY : RESP_SLVERR;
            if (w_aw_word == A_CTRL && S_AXI_WSTRB[0])
               r_gen <= S_AXI_WDATA[0];
            if (w_aw_word == A_SCRATCH)
               for (int unsigned b = 0; b < 4; b++)
                  if (S_AXI_WSTRB[b]) r_scratch[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            for (int unsigned i = 0; i < NUM_CH; i++) begin
               if (w_ch_wr[i]) begin
                  if (S_AXI_WSTRB[0]) r_div[i] <= S_AXI_WDATA[4:0];
                  if (S_AXI_WSTRB[1]) r_en[i]  <= S_AXI_WDATA[8];
`ifdef LED_BANK_PWM_EN
                  if (S_AXI_WSTRB[2]) r_duty[i] <= S_AXI_WDATA[23:16];
                  if (S_AXI_WSTRB[3]) r_mode[i] <= S_AXI_WDATA[24];
`endif
               end
            end
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // read channel; build-ID inputs are captured on the accepting edge
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= w_rd_go;
         if (r_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // channel counters and registered LED outputs
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_led <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_div_chg[i])
               r_cnt[i] <= '0;
            else if (r_gen && r_en[i])
               r_cnt[i] <= r_cnt[i] + 32'd1;
`ifdef LED_BANK_PWM_EN
            if (r_mode[i])
               r_led[i] <= r_gen & r_en[i] & (r_cnt[i][7:0] < r_duty[i]);
            else
               r_led[i] <= r_gen & r_en[i] & r_cnt[i][r_div[i]];
`else
            r_led[i] <= r_gen & r_en[i] & r_cnt[i][r_div[i]];
`endif
         end
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign led_o         = r_led;

endmodule

// File: tb/tb_axil_led_bank.sv
// -----------------------------------------------------------------------------
// tb_axil_led_bank
//   Directed bench for axil_led_bank (NUM_CH=2). Inputs change and outputs are
//   sampled 1 ns after the rising edge. tb_cyc counts rising edges so that LED
//   timing can be measured from the cycle in which BVALID is first observed.
// -----------------------------------------------------------------------------
module tb_axil_led_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] git_hash;
   logic [31:0] timestamp;
   logic [6:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [6:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [1:0]  led_o;

   int checks = 0;
   int errors = 0;
   int tb_cyc = 0;

   axil_led_bank #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(7),
      .NUM_CH(2),
      .RST_DIV(26)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARESETN(rst_n),
      .git_hash(git_hash),
      .timestamp(timestamp),
      .S_AXI_AWADDR(S_AXI_AWADDR),
      .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA),
      .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR),
      .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA),
      .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID),
      .S_AXI_RREADY(S_AXI_RREADY),
      .led_o(led_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write; bc = tb_cyc at the first sample that shows BVALID high.
   task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] r, output int bc);
      logic got;
      got = 1'b0;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         if (S_AXI_AWREADY) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL write_timeout addr=%h awready never seen", a);
         S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; r = 2'b11; bc = 0;
         return;
      end
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      for (int n = 0; n < 20 && !S_AXI_BVALID; n++) tick();
      if (!S_AXI_BVALID) begin
         checks++; errors++;
         $display("FAIL bvalid_timeout addr=%h", a);
         r = 2'b11; bc = 0;
         return;
      end
      r = S_AXI_BRESP; bc = tb_cyc;
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
   endtask

   // Full read; RREADY is held low for 'hold' cycles after RVALID, and 'held'
   // reports whether RVALID and RDATA stayed stable through that window.
   task automatic axi_read(input logic [6:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r, output logic held);
      logic got;
      got = 1'b0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         if (S_AXI_ARREADY) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL read_timeout addr=%h arready never seen", a);
         S_AXI_ARVALID = 1'b0; d = '0; r = 2'b11; held = 1'b0;
         return;
      end
      tick();
      S_AXI_ARVALID = 1'b0;
      d = S_AXI_RDATA; r = S_AXI_RRESP; held = S_AXI_RVALID;
      for (int k = 0; k < hold; k++) begin
         tick();
         if (!S_AXI_RVALID || S_AXI_RDATA !== d) held = 1'b0;
      end
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic [1:0] r; logic h;
      logic [31:0] exp_d [3];
      exp_d[0] = 32'h89AB_CDEF; exp_d[1] = 32'h0123_4567; exp_d[2] = 32'h6502_1A3C;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0 ||
          S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== 2'b00 || S_AXI_BRESP !== 2'b00 || led_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs got rdy/vld=%b rdata=%h led=%b required all zero",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID}, S_AXI_RDATA, led_o);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         axi_read(7'(4 * i), 3, d, r, h);
         checks++;
         if (d !== exp_d[i] || r !== 2'b00 || h !== 1'b1) begin
            errors++;
            $display("FAIL id_read[%0d] got data=%h resp=%b held=%b required %h 00 1", i, d, r, h, exp_d[i]);
         end
      end
      axi_read(7'h0C, 0, d, r, h);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL ctrl_reset got %h required 00000001", d);
      end
      axi_read(7'h20, 0, d, r, h);
      checks++;
      if (d !== 32'h0000_011A) begin
         errors++;
         $display("FAIL ch0_reset got %h required 0000011a", d);
      end
   endtask

   task automatic test_blink();
      logic [31:0] d; logic [1:0] r; logic h; int bc; int m; logic exp_l;
      axi_write(7'h20, 32'h0000_0102, 4'hF, r, bc);
      checks++;
      if (r !== 2'b00) begin
         errors++;
         $display("FAIL ch0_bresp got %b required 00", r);
      end
      // counter cleared on the write edge; LED lags counter bit 2 by one cycle
      for (int k = 0; k < 20; k++) begin
         tick();
         m = tb_cyc - bc;
         exp_l = ((m - 1) >> 2) & 1;
         checks++;
         if (led_o[0] !== exp_l) begin
            errors++;
            $display("FAIL blink_div2 m=%0d got %b required %b", m, led_o[0], exp_l);
         end
      end
      axi_read(7'h20, 0, d, r, h);
      checks++;
      if (d !== 32'h0000_0102 || r !== 2'b00) begin
         errors++;
         $display("FAIL ch0_readback got %h/%b required 00000102/00", d, r);
      end
   endtask

   task automatic test_unmapped();
      logic [31:0] d; logic [1:0] r; logic h; int bc;
      axi_write(7'h7C, 32'hFFFF_FFFF, 4'hF, r, bc);
      checks++;
      if (r !== 2'b10) begin
         errors++;
         $display("FAIL unmapped_bresp got %b required 10", r);
      end
      axi_read(7'h7C, 0, d, r, h);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
         errors++;
         $display("FAIL unmapped_read got %h/%b required 00000000/10", d, r);
      end
      axi_read(7'h18, 0, d, r, h);
      checks++;
      if (d !== 32'h0 || r !== 2'b10) begin
         errors++;
         $display("FAIL hole_read got %h/%b required 00000000/10", d, r);
      end
      axi_write(7'h00, 32'hDEAD_BEEF, 4'hF, r, bc);
      checks++;
      if (r !== 2'b00) begin
         errors++;
         $display("FAIL ro_write_bresp got %b required 00", r);
      end
      axi_read(7'h00, 0, d, r, h);
      checks++;
      if (d !== 32'h89AB_CDEF) begin
         errors++;
         $display("FAIL ro_unchanged got %h required 89abcdef", d);
      end
      axi_read(7'h14, 0, d, r, h);
      checks++;
      if (d !== 32'h0 || r !== 2'b00) begin
         errors++;
         $display("FAIL scratch_unchanged got %h/%b required 00000000/00", d, r);
      end
      axi_read(7'h20, 0, d, r, h);
      checks++;
      if (d !== 32'h0000_0102) begin
         errors++;
         $display("FAIL ch0_unchanged got %h required 00000102", d);
      end
   endtask

   task automatic test_strobe_and_freeze();
      logic [31:0] d; logic [1:0] r; logic h;
      int bc1, bc2, bc3, frozen, rise, bad;
      axi_write(7'h14, 32'hFFFF_FFFF, 4'b0101, r, bc1);
      axi_read(7'h14, 0, d, r, h);
      checks++;
      if (d !== 32'h00FF_00FF) begin
         errors++;
         $display("FAIL scratch_wstrb got %h required 00ff00ff", d);
      end
      // DIV 2->4 clears the counter; its value at freeze is the cycle distance
      // between the two BVALID observations.
      axi_write(7'h20, 32'h0000_0104, 4'hF, r, bc1);
      axi_write(7'h0C, 32'h0, 4'hF, r, bc2);
      frozen = bc2 - bc1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (led_o !== 2'b00) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL gen_off_leds got %0d cycles lit required 0", bad);
      end
      axi_write(7'h0C, 32'h1, 4'hF, r, bc3);
      rise = -1;
      for (int k = 0; k < 40 && rise < 0; k++) begin
         tick();
         if (led_o[0] === 1'b1) rise = tb_cyc - bc3;
      end
      checks++;
      if (rise != 17 - frozen) begin
         errors++;
         $display("FAIL resume_from_frozen got rise at %0d required %0d (frozen cnt %0d)", rise, 17 - frozen, frozen);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic [1:0] r; logic h; logic early, got, acc;
      int bcount;
      S_AXI_AWADDR = 7'h14; S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      early = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (S_AXI_AWREADY || S_AXI_WREADY) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++;
         $display("FAIL aw_only_ready got ready=1 required 0 before W valid");
      end
      S_AXI_WVALID = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         if (S_AXI_AWREADY) got = 1'b1;
      end
      checks++;
      if (!got || S_AXI_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL ready_pair got awready=%b wready=%b required 1 1", got, S_AXI_WREADY);
      end
      tick();
      checks++;
      if (S_AXI_AWREADY !== 1'b0 || S_AXI_BVALID !== 1'b1) begin
         errors++;
         $display("FAIL ready_pulse got awready=%b bvalid=%b required 0 1", S_AXI_AWREADY, S_AXI_BVALID);
      end
      // second write presented while the first response is still pending
      S_AXI_WDATA = 32'h1234_5678;
      bcount = 0; acc = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (S_AXI_BVALID) bcount++;
         if (S_AXI_AWREADY) acc = 1'b1;
         tick();
      end
      checks++;
      if (bcount != 5 || acc !== 1'b0) begin
         errors++;
         $display("FAIL bvalid_hold got bvalid cycles=%0d stalled_accept=%b required 5 0", bcount, acc);
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         tick();
         if (S_AXI_AWREADY) got = 1'b1;
      end
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      checks++;
      if (!got || S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
         errors++;
         $display("FAIL second_write got accepted=%b bvalid=%b bresp=%b required 1 1 00", got, S_AXI_BVALID, S_AXI_BRESP);
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      axi_read(7'h14, 0, d, r, h);
      checks++;
      if (d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL scratch_after_b2b got %h required 12345678", d);
      end
   endtask

   task automatic test_pwm();
      logic [31:0] d; logic [1:0] r; logic h; int bc; int m; int highs; logic exp_l;
      axi_write(7'h24, 32'h0140_0100, 4'hF, r, bc);
      axi_read(7'h24, 0, d, r, h);
`ifdef LED_BANK_PWM_EN
      checks++;
      if (d !== 32'h0140_0100) begin
         errors++;
         $display("FAIL ch1_pwm_readback got %h required 01400100", d);
      end
      highs = 0;
      for (int k = 0; k < 256; k++) begin
         tick();
         if (led_o[1] === 1'b1) highs++;
      end
      checks++;
      if (highs != 64) begin
         errors++;
         $display("FAIL pwm_duty64 got %0d high of 256 required 64", highs);
      end
`else
      checks++;
      if (d !== 32'h0000_0100) begin
         errors++;
         $display("FAIL ch1_blink_readback got %h required 00000100", d);
      end
      // DIV 26->0 cleared the counter at the write edge, so LED = bit0 delayed
      highs = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         m = tb_cyc - bc;
         exp_l = (m - 1) & 1;
         if (led_o[1] !== exp_l) highs++;
      end
      checks++;
      if (highs != 0) begin
         errors++;
         $display("FAIL ch1_blink_div0 got %0d wrong cycles required 0", highs);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      git_hash = 64'h0123_4567_89AB_CDEF;
      timestamp = 32'h6502_1A3C;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      test_reset();
      test_blink();
      test_unmapped();
      test_strobe_and_freeze();
      test_back_to_back();
      test_pwm();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
